tile_accum_writer: RTL and testbench
====================================

# tile_accum_writer

Downstream stage of the 2x2 base matrix multiplier. It sums the K_TILES partial 2x2 product tiles that make up one output block of C, then writes the four finished words into the RAM as one output block. It takes the control unit's start and tile base address, uses the multiplier's done pulse as its data-valid, and drives the RAM write port.

## Interface
- DATA_W, 32: element width in bits, two's complement
- ADDR_W, 9: RAM address width
- K_TILES, 4: partial tiles summed per output block, must be at least 1
- ROW_STRIDE, 16: words between vertically adjacent C elements in RAM
- clk  in  1  clock; every register updates on the rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse that begins a new output block; honoured only in IDLE
- i_base_addr  in  ADDR_W  RAM address of c11; latched when start is honoured
- i_valid  in  1  partial tile present this cycle (base multiplier done)
- i_c11, i_c12, i_c21, i_c22  in  DATA_W each  partial product tile
- o_ready  out  1  high while the block is in ACCUM
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse after the fourth RAM write
- err  out  1  sticky overflow flag; cleared by start or reset

## Operation
- States:
  - IDLE: start moves the block to ACCUM, clears the four accumulators and the tile counter, and latches i_base_addr.
  - ACCUM: each cycle with i_valid high adds i_cXY into accXY and increments the counter. When the K_TILES-th tile is accepted, the next state is WRITE.
  - WRITE: four consecutive cycles, write index 0 to 3, then the next state is DONE.
  - DONE: one cycle, then IDLE.
- Write order:
  - index 0: acc11 to base
  - index 1: acc12 to base+1
  - index 2: acc21 to base+ROW_STRIDE
  - index 3: acc22 to base+ROW_STRIDE+1
- Address sums wrap modulo 2^ADDR_W.
- i_valid outside ACCUM is ignored. start outside IDLE is ignored.
- If start and i_valid are both high in IDLE, only the start is taken.
- Addition is signed DATA_W with no widening (see Configuration).
- Reset mid-operation: all state is lost, the block returns to IDLE, and a partially written output block is abandoned.

## Timing
- Reset values: o_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, err=0, state IDLE.
- start sampled at edge N gives ACCUM and o_ready=1 in cycle N+1.
- A tile accepted at edge M is in the accumulator from cycle M+1 onward.
- If the last tile is accepted at edge L:
  - ram_we is high with registered address and data in cycles L+1 to L+4.
  - done is high in cycle L+5.
  - busy is low from L+6.
- i_valid may have gaps of any length; there is no timeout.
- ram_we, ram_addr and ram_wdata come straight from registers. ram_addr and ram_wdata hold their last values when ram_we is low.

## Configuration
- SAT_ACCUM_EN defined:
  - Each addition saturates to the signed DATA_W range, either 0x7FFF_FFFF or 0x8000_0000.
  - Any saturation event sets err.
- SAT_ACCUM_EN undefined:
  - Additions wrap modulo 2^DATA_W.
  - err is tied to 0.

## Structure
- Shared package matmul_pkg holds:
  - the state enum: IDLE, ACCUM, WRITE, DONE
  - the write-index type
  - default DATA_W and ADDR_W constants
- Sub-module acc_add: one signed adder with optional saturation and an overflow flag output. It is instantiated four times, and is the only place SAT_ACCUM_EN is tested.
- Top level holds the FSM, the tile counter, the write index and the address generation.

## Test plan
Bench configuration for all cases: K_TILES=2, ROW_STRIDE=4, DATA_W=32, ADDR_W=9.
- Reset: with rst low, every output is 0 and the state is IDLE. After rst rises, outputs stay at 0 with no start.
- Basic: start with base 0x010, then tiles (1,2,3,4) and (5,6,7,8).
  - Required writes: 6@0x010, 8@0x011, 10@0x014, 12@0x015 on consecutive cycles.
  - done is high exactly 5 cycles after the second tile is accepted.
- Gaps and ignores:
  - Apply i_valid in IDLE, insert a 3-cycle gap between tiles, and pulse start while busy.
  - The stray valid and the stray start have no effect, and the output sums match the Basic case.
- Overflow: tiles with c11 = 0x7FFF_FFFF and then 1.
  - With SAT_ACCUM_EN: writes 0x7FFF_FFFF and err=1.
  - Without SAT_ACCUM_EN: writes 0x8000_0000 and err=0.
- Address wrap: base 0x1FF gives write addresses 0x1FF, 0x000, 0x003, 0x004.
- Reset mid-write: drop rst after the second write.
  - ram_we falls immediately and the state returns to IDLE.
  - done is never asserted.
  - A following start runs a clean block.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and defaults for the 2x2 base matrix multiplier datapath.
//   state_e   : tile_accum_writer FSM states
//   wr_idx_t  : index of the output word being written (0..3)
//   DEF_*     : default element and RAM address widths
package matmul_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned NUM_ELEM   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] wr_idx_t;

endpackage

// File: rtl/acc_add.sv
// Signed DATA_W adder used for one accumulator element.
// Optional feature macro: SAT_ACCUM_EN
//   defined   : result saturates to the signed range, ovf_c flags saturation
//   undefined : result wraps modulo 2^DATA_W, ovf_c is 0
// Ports:
//   i_a, i_b : addends (two's complement)
//   sum_c    : combinational sum
//   ovf_c    : combinational overflow/saturation flag
module acc_add
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] sum_c,
  output logic              ovf_c
);

  logic [DATA_W-1:0] raw_c;

  assign raw_c = i_a + i_b;

`ifdef SAT_ACCUM_EN
  // Overflow only when both addends share a sign the result does not.
  always_comb begin
    ovf_c = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (raw_c[DATA_W-1] != i_a[DATA_W-1]);
    sum_c = raw_c;
    if (ovf_c) begin
      sum_c = i_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sum_c = raw_c;
    ovf_c = 1'b0;
  end
`endif

endmodule

// File: rtl/tile_accum_writer.sv
// Sums K_TILES partial 2x2 product tiles into one output block of C and
// writes the four finished words to RAM (c11, c12, c21, c22).
// Optional feature macro: SAT_ACCUM_EN (saturating accumulation, sticky err).
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   start, i_base_addr    : begin a block at the given c11 address (IDLE only)
//   i_valid, i_c11..i_c22 : partial tile, accepted only in ACCUM
//   o_ready               : block is in ACCUM
//   ram_we/addr/wdata     : registered RAM write port
//   busy, done, err       : status (done is a one-cycle pulse, err is sticky)
module tile_accum_writer
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned K_TILES    = 4,
  parameter int unsigned ROW_STRIDE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_c11,
  input  logic [DATA_W-1:0] i_c12,
  input  logic [DATA_W-1:0] i_c21,
  input  logic [DATA_W-1:0] i_c22,
  output logic              o_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned       CNT_W    = (K_TILES > 1) ? $clog2(K_TILES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(K_TILES - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ROW_STRIDE);

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  wr_idx_t                           idx_q, idx_d;
  logic [ADDR_W-1:0]                 base_q, base_d;
  logic [NUM_ELEM-1:0][DATA_W-1:0]   acc_q, acc_d;
  logic                              err_q, err_d;
  logic                              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]                 ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]                 ram_wdata_q, ram_wdata_d;
  logic                              done_q, done_d;
  logic                              busy_q, busy_d;
  logic                              o_ready_q, o_ready_d;

  logic [NUM_ELEM-1:0][DATA_W-1:0]   tile_c;
  logic [NUM_ELEM-1:0][DATA_W-1:0]   sum_c;
  logic [NUM_ELEM-1:0]               ovf_c;
  wr_idx_t                           idx_nxt_c;

  assign tile_c    = {i_c22, i_c21, i_c12, i_c11};
  assign idx_nxt_c = idx_q + wr_idx_t'(1);

  // One adder per element: accumulator plus incoming tile element.
  for (genvar e = 0; e < NUM_ELEM; e++) begin : g_add
    acc_add #(.DATA_W(DATA_W)) u_acc_add (
      .i_a   (acc_q[e]),
      .i_b   (tile_c[e]),
      .sum_c (sum_c[e]),
      .ovf_c (ovf_c[e])
    );
  end

  // RAM address of output word idx relative to c11; sums wrap naturally.
  function automatic logic [ADDR_W-1:0] wr_addr(input logic [ADDR_W-1:0] base,
                                                input wr_idx_t           idx);
    case (idx)
      2'd0:    wr_addr = base;
      2'd1:    wr_addr = base + ADDR_W'(1);
      2'd2:    wr_addr = base + STRIDE_A;
      default: wr_addr = base + STRIDE_A + ADDR_W'(1);
    endcase
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    base_d      = base_q;
    acc_d       = acc_q;
    err_d       = err_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          idx_d   = '0;
          acc_d   = '0;
          base_d  = i_base_addr;
          err_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (i_valid) begin
          acc_d = sum_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (|ovf_c) err_d = 1'b1;
          // Last tile: launch word 0 straight from the adder so the first
          // write lands in the cycle right after acceptance.
          if (cnt_q == LAST_CNT) begin
            state_d     = WRITE;
            idx_d       = '0;
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr(base_q, 2'd0);
            ram_wdata_d = sum_c[0];
          end
        end
      end
      WRITE: begin
        // idx_q names the word currently on the RAM port.
        if (idx_q == 2'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d       = idx_nxt_c;
          ram_we_d    = 1'b1;
          ram_addr_d  = wr_addr(base_q, idx_nxt_c);
          ram_wdata_d = acc_q[idx_nxt_c];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = (state_d != IDLE);
    o_ready_d = (state_d == ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      o_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      o_ready_q   <= o_ready_d;
    end
  end

  assign o_ready   = o_ready_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tile_accum_writer.sv
// Bench for tile_accum_writer: directed cases plus randomized blocks checked
// against a plain-arithmetic model of the expected output block.
module tb_tile_accum_writer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned KT = 2;
  localparam int unsigned RS = 4;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] i_base_addr;
  logic          i_valid;
  logic [DW-1:0] i_c11, i_c12, i_c21, i_c22;
  logic          o_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          busy;
  logic          done;
  logic          err;

  tile_accum_writer #(
    .DATA_W(DW), .ADDR_W(AW), .K_TILES(KT), .ROW_STRIDE(RS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .i_base_addr(i_base_addr),
    .i_valid(i_valid), .i_c11(i_c11), .i_c12(i_c12), .i_c21(i_c21), .i_c22(i_c22),
    .o_ready(o_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] tl [KT][4];
  logic [DW-1:0] exp_w [4];
  logic [AW-1:0] exp_a [4];
  bit            exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tile(input int t, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
    tl[t][0] = a; tl[t][1] = b; tl[t][2] = c; tl[t][3] = d;
  endtask

  // Expected block: element-wise sum of all tiles, then the fixed write layout.
  function automatic void model(input logic [AW-1:0] base);
    int off [4];
    off = '{0, 1, RS, RS + 1};
    exp_err = 1'b0;
    for (int e = 0; e < 4; e++) begin
      longint acc = 0;
      for (int t = 0; t < KT; t++) begin
        longint s = acc + longint'($signed(tl[t][e]));
`ifdef SAT_ACCUM_EN
        if (s > SMAX) begin s = SMAX; exp_err = 1'b1; end
        else if (s < SMIN) begin s = SMIN; exp_err = 1'b1; end
`else
        s = longint'($signed(32'(s)));
`endif
        acc = s;
      end
      exp_w[e] = 32'(acc);
      exp_a[e] = AW'((int'(base) + off[e]) % (1 << AW));
    end
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_o_ready"}, o_ready, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Run one output block; gaps before each tile are drawn from [glo, ghi].
  // With strays set, start is also held high on gap and write cycles and
  // i_valid with junk data accompanies the real start.
  task automatic run_block(input logic [AW-1:0] base, input int glo, input int ghi,
                           input bit strays, input string tag);
    model(base);
    start = 1'b1; i_base_addr = base;
    i_valid = strays;
    i_c11 = $urandom; i_c12 = $urandom; i_c21 = $urandom; i_c22 = $urandom;
    step();
    start = 1'b0; i_valid = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_ready_after_start"}, o_ready, 1);
    chk({tag, "_err_cleared"}, err, 0);
    for (int t = 0; t < KT; t++) begin
      int g = $urandom_range(ghi, glo);
      for (int k = 0; k < g; k++) begin
        i_c11 = $urandom; i_c12 = $urandom; i_c21 = $urandom; i_c22 = $urandom;
        if (strays) begin start = 1'b1; i_base_addr = ~base; end
        step();
        start = 1'b0;
        chk({tag, "_gap_ready"}, o_ready, 1);
        chk({tag, "_gap_we"}, ram_we, 0);
      end
      i_valid = 1'b1;
      i_c11 = tl[t][0]; i_c12 = tl[t][1]; i_c21 = tl[t][2]; i_c22 = tl[t][3];
      step();
      i_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_we%0d", tag, k), ram_we, 1);
      chk($sformatf("%s_addr%0d", tag, k), ram_addr, exp_a[k]);
      chk($sformatf("%s_data%0d", tag, k), ram_wdata, exp_w[k]);
      chk($sformatf("%s_done_early%0d", tag, k), done, 0);
      if (strays) begin start = 1'b1; i_base_addr = ~base; end
      step();
      start = 1'b0;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_we_off"}, ram_we, 0);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_in_done"}, busy, 1);
    chk({tag, "_addr_hold"}, ram_addr, exp_a[3]);
    chk({tag, "_data_hold"}, ram_wdata, exp_w[3]);
    step();
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_ready_end"}, o_ready, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; i_base_addr = '0; i_valid = 1'b0;
    i_c11 = '0; i_c12 = '0; i_c21 = '0; i_c22 = '0;

    // Reset values while held and after release.
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst_held");
    chk("rst_held_addr", ram_addr, 0);
    chk("rst_held_wdata", ram_wdata, 0);
    chk("rst_held_err", err, 0);
    rst = 1'b1;
    repeat (3) step();
    check_idle("rst_released");
    chk("rst_released_addr", ram_addr, 0);
    chk("rst_released_err", err, 0);

    // Basic block.
    set_tile(0, 1, 2, 3, 4);
    set_tile(1, 5, 6, 7, 8);
    run_block(9'h010, 0, 0, 1'b0, "basic");
    chk("basic_model_w0", exp_w[0], 6);

    // Stray valid in IDLE, 3-cycle gaps, start pulses while busy.
    i_valid = 1'b1; i_c11 = 32'h1234; i_c12 = 32'h55; i_c21 = 32'h7; i_c22 = 32'h9;
    repeat (2) step();
    i_valid = 1'b0;
    check_idle("stray_valid");
    run_block(9'h010, 3, 3, 1'b1, "gaps");

    // Overflow on c11.
    set_tile(0, 32'h7FFF_FFFF, 10, 20, 30);
    set_tile(1, 32'h0000_0001, 1, 2, 3);
    run_block(9'h020, 0, 1, 1'b0, "ovf");
    // err is sticky until the next start clears it.
    chk("ovf_err_sticky", err, exp_err);

    // Address wrap.
    set_tile(0, 11, 22, 33, 44);
    set_tile(1, -32'sd1, -32'sd2, -32'sd3, -32'sd4);
    run_block(9'h1FF, 0, 0, 1'b0, "wrap");

    // Reset after the second write.
    set_tile(0, 100, 200, 300, 400);
    set_tile(1, 1, 2, 3, 4);
    model(9'h040);
    start = 1'b1; i_base_addr = 9'h040; step(); start = 1'b0;
    for (int t = 0; t < KT; t++) begin
      i_valid = 1'b1;
      i_c11 = tl[t][0]; i_c12 = tl[t][1]; i_c21 = tl[t][2]; i_c22 = tl[t][3];
      step();
    end
    i_valid = 1'b0;
    chk("midrst_w0_data", ram_wdata, exp_w[0]);
    step();
    chk("midrst_w1_we", ram_we, 1);
    chk("midrst_w1_addr", ram_addr, exp_a[1]);
    rst = 1'b0;
    #1;
    check_idle("midrst_async");
    step();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("midrst_quiet%0d", k), done | ram_we | busy, 0);
    end
    set_tile(0, 7, 8, 9, 10);
    set_tile(1, 3, 2, 1, 0);
    run_block(9'h040, 0, 0, 1'b0, "after_rst");

    // Randomized blocks.
    for (int b = 0; b < 20; b++) begin
      for (int t = 0; t < KT; t++) begin
        for (int e = 0; e < 4; e++) begin
          tl[t][e] = ($urandom_range(0, 3) == 0) ? $urandom : DW'($urandom_range(0, 2000)) - 32'd1000;
        end
      end
      run_block(AW'($urandom_range(0, 511)), 0, 3, b[0], $sformatf("rand%0d", b));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
